dsp_conv_unit: RTL and testbench



---
 rtl/dsp_conv_unit_if.sv | 39 +++
 rtl/dsp_conv_unit.sv | 177 +++++++++++++++++
 tb/tb_dsp_conv_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_conv_unit_if.sv
// Pipeline-side bus of the convolution coprocessor: operand writes, launch controls and result stream.
interface dsp_conv_unit_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned OUT_W   = 32
);
  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned LW = AW + 1;

  logic              wr_a_en;
  logic              wr_b_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LW-1:0]     len_a;
  logic [LW-1:0]     len_b;
  logic              cfg_signed;
  logic [5:0]        cfg_shift;
  logic              start;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              out_sat;
  logic              done;
  logic              err;

  modport master (
    output wr_a_en, wr_b_en, wr_addr, wr_data, len_a, len_b,
           cfg_signed, cfg_shift, start, out_ready,
    input  busy, out_valid, out_data, out_last, out_sat, done, err
  );

  modport slave (
    input  wr_a_en, wr_b_en, wr_addr, wr_data, len_a, len_b,
           cfg_signed, cfg_shift, start, out_ready,
    output busy, out_valid, out_data, out_last, out_sat, done, err
  );
endinterface

// File: rtl/dsp_conv_unit.sv
// Linear-convolution coprocessor: two indexed operand buffers, one MAC per cycle,
// shifted/saturated results streamed over valid/ready.
module dsp_conv_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned ACC_W   = 36,
  parameter int unsigned OUT_W   = 32
) (
  input  logic           clk,
  input  logic           reset,
  dsp_conv_unit_if.slave bus
);
  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned JW = LW + 1;
  localparam int unsigned PW = 2 * DATA_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem_a [MAX_LEN];
  logic [DATA_W-1:0] r_mem_b [MAX_LEN];
  logic [LW-1:0]     r_len_a;
  logic [LW-1:0]     r_len_b;
  logic [LW-1:0]     r_n;
  logic [LW-1:0]     r_n_last;
  logic [AW-1:0]     r_k;
  logic              r_signed;
  logic [5:0]        r_shift;
  logic [ACC_W-1:0]  r_acc;
  logic              r_busy;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_out_sat;
  logic              r_done;
  logic              r_err;
  logic [OUT_W-1:0]  r_out_data;

  logic                     w_start_ok;
  logic [JW-1:0]            w_j;
  logic                     w_j_ok;
  logic                     w_k_last;
  logic signed [DATA_W:0]   w_ext_a;
  logic signed [DATA_W:0]   w_ext_b;
  logic signed [PW-1:0]     w_prod;
  logic [ACC_W-1:0]         w_acc_nxt;
  logic signed [ACC_W-1:0]  w_shr_s;
  logic signed [ACC_W-1:0]  w_top_s;
  logic [ACC_W-1:0]         w_shr_u;
  logic [ACC_W-1:0]         w_top_u;
  logic [OUT_W-1:0]         w_sat_data;
  logic                     w_sat;

  // Current MAC term: j = n - k, contributes only while 0 <= j < len_b.
  always_comb begin
    w_start_ok = (bus.len_a != '0) && (bus.len_a <= LW'(MAX_LEN)) &&
                 (bus.len_b != '0) && (bus.len_b <= LW'(MAX_LEN));
    w_j        = JW'(r_n) - JW'(r_k);
    w_j_ok     = !w_j[JW-1] && (w_j[LW-1:0] < r_len_b);
    w_k_last   = (LW'(r_k) == (r_len_a - LW'(1)));
    w_ext_a    = r_signed ? {r_mem_a[r_k][DATA_W-1], r_mem_a[r_k]} : {1'b0, r_mem_a[r_k]};
    w_ext_b    = r_signed ? {r_mem_b[w_j[AW-1:0]][DATA_W-1], r_mem_b[w_j[AW-1:0]]}
                          : {1'b0, r_mem_b[w_j[AW-1:0]]};
    w_prod     = PW'(w_ext_a) * PW'(w_ext_b);
    w_acc_nxt  = w_j_ok ? (r_acc + ACC_W'(w_prod)) : r_acc;
  end

  // Output stage works on the post-MAC accumulator so the sample is ready on the last term.
  always_comb begin
    w_shr_s = $signed(w_acc_nxt) >>> r_shift;
    w_shr_u = w_acc_nxt >> r_shift;
    w_top_s = w_shr_s >>> (OUT_W - 1);
    w_top_u = w_shr_u >> OUT_W;
    if (r_signed) begin
      w_sat      = (w_top_s != '0) && (w_top_s != '1);
      w_sat_data = !w_sat          ? OUT_W'(w_shr_s) :
                   w_shr_s[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      w_sat      = (w_top_u != '0);
      w_sat_data = w_sat ? '1 : OUT_W'(w_shr_u);
    end
  end

  // Buffers keep their contents through reset.
  always_ff @(posedge clk) begin
    if (!r_busy) begin
      if (bus.wr_a_en) r_mem_a[bus.wr_addr] <= bus.wr_data;
      if (bus.wr_b_en) r_mem_b[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_len_a     <= '0;
      r_len_b     <= '0;
      r_n         <= '0;
      r_n_last    <= '0;
      r_k         <= '0;
      r_signed    <= 1'b0;
      r_shift     <= '0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_start_ok) begin
              r_len_a  <= bus.len_a;
              r_len_b  <= bus.len_b;
              r_n_last <= bus.len_a + bus.len_b - LW'(2);
              r_signed <= bus.cfg_signed;
              r_shift  <= bus.cfg_shift;
              r_n      <= '0;
              r_k      <= '0;
              r_acc    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_MAC;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_MAC: begin
          r_acc <= w_acc_nxt;
          if (w_k_last) begin
            r_k         <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_sat_data;
            r_out_sat   <= w_sat;
            r_out_last  <= (r_n == r_n_last);
            r_state     <= S_EMIT;
          end else begin
            r_k <= r_k + AW'(1);
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_n     <= r_n + LW'(1);
              r_k     <= '0;
              r_acc   <= '0;
              r_state <= S_MAC;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_sat   = r_out_sat;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_dsp_conv_unit.sv
// Directed bench for dsp_conv_unit: a plain-arithmetic convolution model feeds a per-handshake
// scoreboard, with literal values pinning the key results.
module tb_dsp_conv_unit;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned ACC_W   = 36;
  localparam int unsigned OUT_W   = 32;
  localparam int unsigned LW      = $clog2(MAX_LEN) + 1;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             last;
    logic             sat;
  } smp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  dsp_conv_unit_if #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .OUT_W(OUT_W)) bus ();

  dsp_conv_unit #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] ma [MAX_LEN];
  logic [DATA_W-1:0] mb [MAX_LEN];
  smp_t expq[$];
  smp_t snap[$];
  smp_t got[$];
  smp_t e_cur;
  bit   chk_en = 1'b0;
  bit   done_exp = 1'b0;
  bit   hold_pending = 1'b0;
  logic [OUT_W-1:0] held;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference: direct convolution sum, shift and clamp on 64-bit integers.
  function automatic void model(int la, int lb, bit sg, int sh);
    longint acc, s, ea, eb;
    smp_t e;
    expq.delete();
    for (int n = 0; n <= la + lb - 2; n++) begin
      acc = 0;
      for (int k = 0; k < la; k++) begin
        int j = n - k;
        if (j >= 0 && j < lb) begin
          if (sg) begin
            ea = longint'($signed(ma[k]));
            eb = longint'($signed(mb[j]));
          end else begin
            ea = longint'(ma[k]);
            eb = longint'(mb[j]);
          end
          acc += ea * eb;
        end
      end
      s = acc >>> sh;
      e.sat = 1'b0;
      if (sg) begin
        if (s > 64'sd2147483647) begin s = 64'sd2147483647; e.sat = 1'b1; end
        else if (s < -64'sd2147483648) begin s = -64'sd2147483648; e.sat = 1'b1; end
      end else if (s > 64'sd4294967295) begin
        s = 64'sd4294967295;
        e.sat = 1'b1;
      end
      e.d    = 32'(s);
      e.last = (n == la + lb - 2);
      expq.push_back(e);
    end
  endfunction

  function automatic logic [63:0] gd(int i);
    return (got.size() > i) ? 64'(got[i].d) : '1;
  endfunction

  function automatic logic [63:0] gl(int i);
    return (got.size() > i) ? 64'(got[i].last) : '1;
  endfunction

  function automatic logic [63:0] gs(int i);
    return (got.size() > i) ? 64'(got[i].sat) : '1;
  endfunction

  function automatic int basic_lit(int i);
    case (i)
      0:       return 4;
      1:       return 13;
      2:       return 22;
      default: return 15;
    endcase
  endfunction

  function automatic void check_basic(string tag);
    check({tag, "_count"}, 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_data%0d", tag, i), gd(i), 64'(basic_lit(i)));
      check($sformatf("%s_last%0d", tag, i), gl(i), 64'(i == 3));
    end
  endfunction

  // Scoreboard: every accepted sample against the model, plus hold and done-pulse rules.
  always @(negedge clk) begin
    if (chk_en) begin
      check("done_pulse", 64'(bus.done), 64'(done_exp));
      done_exp = 1'b0;
      if (hold_pending) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(bus.out_data), 64'(held));
      end
      hold_pending = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back({bus.out_data, bus.out_last, bus.out_sat});
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_sample: got data %0d with no sample expected", bus.out_data);
        end else begin
          e_cur = expq.pop_front();
          check("sample_data", 64'(bus.out_data), 64'(e_cur.d));
          check("sample_last", 64'(bus.out_last), 64'(e_cur.last));
          check("sample_sat", 64'(bus.out_sat), 64'(e_cur.sat));
        end
        if (bus.out_last) done_exp = 1'b1;
      end else if (bus.out_valid) begin
        hold_pending = 1'b1;
        held = bus.out_data;
      end
    end
  end

  task automatic wr(input bit a, input bit b, input int addr, input logic [DATA_W-1:0] d);
    bus.wr_a_en = a;
    bus.wr_b_en = b;
    bus.wr_addr = 4'(addr);
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_a_en = 1'b0;
    bus.wr_b_en = 1'b0;
    if (a) ma[addr] = d;
    if (b) mb[addr] = d;
  endtask

  // mode 0: ready high; 1: 5-cycle stall on sample 1; 2: start/writes while busy; 3: reset in sample 1.
  task automatic run(input int la, input int lb, input bit sg, input int sh, input int mode,
                     output int first, output int done_cyc, output int stalls);
    bit fin;
    model(la, lb, sg, sh);
    snap = expq;
    got.delete();
    first = -1; done_cyc = -1; stalls = 0; fin = 1'b0;
    bus.len_a = LW'(la);
    bus.len_b = LW'(lb);
    bus.cfg_signed = sg;
    bus.cfg_shift = 6'(sh);
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.wr_a_en = 1'b0;
      if (first < 0 && bus.out_valid) first = cyc;
      if (bus.done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else begin
        case (mode)
          1: begin
            if (got.size() == 1 && bus.out_valid && stalls < 5) begin
              bus.out_ready = 1'b0;
              stalls++;
            end else bus.out_ready = 1'b1;
          end
          2: if (cyc >= 2 && cyc <= 4) begin
            bus.start = 1'b1;
            bus.len_a = LW'(1);
            bus.len_b = LW'(1);
            bus.wr_a_en = 1'b1;
            bus.wr_addr = '0;
            bus.wr_data = 16'd99;
          end
          3: begin
            if (cyc == 6) reset = 1'b0;
            else if (cyc == 7) begin
              check("rst_busy", 64'(bus.busy), 64'd0);
              check("rst_valid", 64'(bus.out_valid), 64'd0);
              check("rst_data", 64'(bus.out_data), 64'd0);
              check("rst_last", 64'(bus.out_last), 64'd0);
              check("rst_sat", 64'(bus.out_sat), 64'd0);
              check("rst_done", 64'(bus.done), 64'd0);
              check("rst_err", 64'(bus.err), 64'd0);
              reset = 1'b1;
              expq.delete();
              fin = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    bus.out_ready = 1'b1;
    if (mode != 3) begin
      check("done_seen", 64'(done_cyc >= 0), 64'd1);
      check("busy_at_done", 64'(bus.busy), 64'd1);
      check("leftover", 64'(expq.size()), 64'd0);
      @(posedge clk); #1;
      check("busy_after_done", 64'(bus.busy), 64'd0);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      check("busy_after_reset", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic bad_start(input int la, input int lb);
    bus.len_a = LW'(la);
    bus.len_b = LW'(lb);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("err_pulse", 64'(bus.err), 64'd1);
    check("err_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check("err_clear", 64'(bus.err), 64'd0);
    check("err_busy_after", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first, dc, st;
    bus.wr_a_en = 1'b0; bus.wr_b_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len_a = '0; bus.len_b = '0; bus.cfg_signed = 1'b0; bus.cfg_shift = '0;
    bus.start = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_data", 64'(bus.out_data), 64'd0);
    check("reset_last", 64'(bus.out_last), 64'd0);
    check("reset_sat", 64'(bus.out_sat), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_err", 64'(bus.err), 64'd0);
    reset = 1'b1;
    chk_en = 1'b1;

    // Basic signed run: 4, 13, 22, 15.
    wr(1, 0, 0, 16'd1); wr(1, 0, 1, 16'd2); wr(1, 0, 2, 16'd3);
    wr(0, 1, 0, 16'd4); wr(0, 1, 1, 16'd5);
    run(3, 2, 1'b1, 0, 0, first, dc, st);
    for (int i = 0; i < 4; i++)
      check($sformatf("model_basic%0d", i), (snap.size() > i) ? 64'(snap[i].d) : '1, 64'(basic_lit(i)));
    check_basic("basic");
    check("first_valid", 64'(first), 64'd4);
    check("done_cycle", 64'(dc), 64'd17);

    run(3, 2, 1'b1, 0, 1, first, dc, st);
    check_basic("backpressure");
    check("stall_cycles", 64'(st), 64'd5);

    bad_start(0, 2);
    bad_start(3, 17);

    run(3, 2, 1'b1, 0, 2, first, dc, st);
    check_basic("overlap");

    // Mode and shift on single-sample runs.
    wr(1, 1, 0, 16'hFFFF);
    run(1, 1, 1'b0, 0, 0, first, dc, st);
    check("unsigned_ffff", gd(0), 64'd4294836225);
    check("unsigned_ffff_sat", gs(0), 64'd0);
    check("first_valid_len1", 64'(first), 64'd2);
    check("done_cycle_len1", 64'(dc), 64'd3);
    run(1, 1, 1'b1, 0, 0, first, dc, st);
    check("signed_ffff", gd(0), 64'd1);
    wr(1, 0, 0, 16'hFFF6); wr(0, 1, 0, 16'd10);
    run(1, 1, 1'b1, 4, 0, first, dc, st);
    check("shift_neg", gd(0), 64'h0000_0000_FFFF_FFF9);
    wr(1, 0, 0, 16'd10);
    run(1, 1, 1'b1, 4, 0, first, dc, st);
    check("shift_pos", gd(0), 64'd6);

    // Saturation with full-length 0x7FFF buffers.
    for (int i = 0; i < 16; i++) wr(1, 1, i, 16'h7FFF);
    run(16, 16, 1'b1, 0, 0, first, dc, st);
    check("sat_count", 64'(got.size()), 64'd31);
    check("sat_first", gd(0), 64'd1073676289);
    check("sat_first_flag", gs(0), 64'd0);
    check("sat_mid", gd(15), 64'd2147483647);
    check("sat_mid_flag", gs(15), 64'd1);
    check("model_sat_flag", (snap.size() > 15) ? 64'(snap[15].sat) : '1, 64'd1);
    check("sat_done_cycle", 64'(dc), 64'd528);

    // Reset during the second sample, then a clean rerun from intact buffers.
    wr(1, 0, 0, 16'd1); wr(1, 0, 1, 16'd2); wr(1, 0, 2, 16'd3);
    wr(0, 1, 0, 16'd4); wr(0, 1, 1, 16'd5);
    run(3, 2, 1'b1, 0, 3, first, dc, st);
    check("pre_reset_samples", 64'(got.size()), 64'd1);
    run(3, 2, 1'b1, 0, 0, first, dc, st);
    check_basic("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
